// File: rtl/csr_exec_unit.sv
// Execute-stage sequencer for RV32 SYSTEM ops (CSRRW/S/C[I], ECALL, MRET).
// Drives the CSR file port set and returns the rd writeback value and PC redirect.
module csr_exec_unit #(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] ECALL_CAUSE = 32'd11
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2:0]              in_op,
    input  logic                    in_use_imm,
    input  logic                    in_src_zero,
    input  logic [11:0]             in_csr_addr,
    input  logic [DATA_WIDTH-1:0]   in_rs1_val,
    input  logic [4:0]              in_zimm,
    input  logic [4:0]              in_rd,
    input  logic [DATA_WIDTH-1:0]   in_pc,

    output logic [11:0]             csr_rd_addr,
    output logic [11:0]             csr_wr_addr,
    output logic                    csr_wren,
    output logic [DATA_WIDTH-1:0]   csr_wdata,
    output logic                    csr_ecallwr,
    output logic                    csr_ecallrd,
    output logic                    csr_mret,
    output logic [2*DATA_WIDTH-1:0] csr_ecall_pkg,
    input  logic [DATA_WIDTH-1:0]   csr_rdata,

    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4:0]              out_rd,
    output logic                    out_rd_wen,
    output logic [DATA_WIDTH-1:0]   out_rd_data,
    output logic                    out_redirect,
    output logic [DATA_WIDTH-1:0]   out_redirect_pc
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_TRAP,
        S_RESP
    } state_e;

    localparam logic [2:0] OP_RW    = 3'b001;
    localparam logic [2:0] OP_RS    = 3'b010;
    localparam logic [2:0] OP_RC    = 3'b011;
    localparam logic [2:0] OP_ECALL = 3'b100;
    localparam logic [2:0] OP_MRET  = 3'b101;

    state_e                  state_q, state_d;
    logic [2:0]              op_q;
    logic                    use_imm_q, src_zero_q;
    logic [11:0]             addr_q;
    logic [DATA_WIDTH-1:0]   rs1_q, pc_q;
    logic [4:0]              zimm_q, rd_q;

    logic [4:0]              out_rd_q, out_rd_d;
    logic                    rd_wen_q, rd_wen_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                    redirect_q, redirect_d;
    logic [DATA_WIDTH-1:0]   redirect_pc_q, redirect_pc_d;

    logic                    accept;
    logic                    is_csr_op;
    logic [DATA_WIDTH-1:0]   src, new_val;

    assign accept    = (state_q == S_IDLE) && in_valid;
    assign is_csr_op = (op_q == OP_RW) || (op_q == OP_RS) || (op_q == OP_RC);
    assign src       = use_imm_q ? {{(DATA_WIDTH-5){1'b0}}, zimm_q} : rs1_q;

    always_comb begin
        unique case (op_q)
            OP_RS:   new_val = csr_rdata | src;
            OP_RC:   new_val = csr_rdata & ~src;
            default: new_val = src;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            op_q          <= '0;
            use_imm_q     <= 1'b0;
            src_zero_q    <= 1'b0;
            addr_q        <= '0;
            rs1_q         <= '0;
            zimm_q        <= '0;
            rd_q          <= '0;
            pc_q          <= '0;
            out_rd_q      <= '0;
            rd_wen_q      <= 1'b0;
            rd_data_q     <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            out_rd_q      <= out_rd_d;
            rd_wen_q      <= rd_wen_d;
            rd_data_q     <= rd_data_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            if (accept) begin
                op_q       <= in_op;
                use_imm_q  <= in_use_imm;
                src_zero_q <= in_src_zero;
                addr_q     <= in_csr_addr;
                rs1_q      <= in_rs1_val;
                zimm_q     <= in_zimm;
                rd_q       <= in_rd;
                pc_q       <= in_pc;
            end
        end
    end

    // NOTE: every output and next-state signal gets a default first, so no
    // path through the case statement can infer a latch.
    always_comb begin
        state_d       = state_q;
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        csr_rd_addr   = '0;
        csr_wr_addr   = '0;
        csr_wren      = 1'b0;
        csr_wdata     = '0;
        csr_ecallwr   = 1'b0;
        csr_ecallrd   = 1'b0;
        csr_mret      = 1'b0;
        csr_ecall_pkg = '0;
        out_rd_d      = out_rd_q;
        rd_wen_d      = rd_wen_q;
        rd_data_d     = rd_data_q;
        redirect_d    = redirect_q;
        redirect_pc_d = redirect_pc_q;

        unique case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = S_EXEC;
            end
            S_EXEC: begin
                out_rd_d      = rd_q;
                rd_wen_d      = 1'b0;
                rd_data_d     = '0;
                redirect_d    = 1'b0;
                redirect_pc_d = '0;
                state_d       = S_RESP;
                if (is_csr_op) begin
                    csr_rd_addr = addr_q;
                    rd_data_d   = csr_rdata;
                    rd_wen_d    = (rd_q != 5'd0);
                    // Set/clear with a zero source is a pure read; RW always writes.
                    if ((op_q == OP_RW) || !src_zero_q) begin
                        csr_wren    = 1'b1;
                        csr_wr_addr = addr_q;
                        csr_wdata   = new_val;
                    end
                end else if (op_q == OP_ECALL) begin
                    csr_ecallwr   = 1'b1;
                    csr_ecall_pkg = {ECALL_CAUSE, pc_q};
                    state_d       = S_TRAP;
                end else if (op_q == OP_MRET) begin
                    csr_mret      = 1'b1;
                    redirect_d    = 1'b1;
                    redirect_pc_d = csr_rdata;
                end
            end
            S_TRAP: begin
                csr_ecallrd   = 1'b1;
                redirect_d    = 1'b1;
                redirect_pc_d = csr_rdata;
                state_d       = S_RESP;
            end
            S_RESP: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    redirect_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A reset in flight must never let a CSR side effect escape.
        if (rst) begin
            csr_wren    = 1'b0;
            csr_ecallwr = 1'b0;
            csr_ecallrd = 1'b0;
            csr_mret    = 1'b0;
        end
    end

    assign out_rd          = out_rd_q;
    assign out_rd_wen      = rd_wen_q;
    assign out_rd_data     = rd_data_q;
    assign out_redirect    = redirect_q;
    assign out_redirect_pc = redirect_pc_q;

endmodule

// File: doc/csr_exec_unit.md
Name: csr_exec_unit

Overview:
- Execute-stage sequencer for RV32 SYSTEM instructions: CSRRW/CSRRS/CSRRC and their immediate forms, ECALL and MRET.
- Accepts one decoded op per valid/ready handshake and drives the CSR register file port set: read address, write address, write enable, ecall write, ecall read, mret, ecall package and write data.
- Samples the CSR read data.
- Returns the rd writeback value and the PC redirect target to the writeback/fetch side.

Parameters:
- DATA_WIDTH, 32, CSR and GPR data width.
- ECALL_CAUSE, 32'd11, mcause value for an environment call from M-mode.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  upstream op valid
- in_ready  out  1  unit can accept; high only in IDLE
- in_op  in  3  001 RW, 010 RS, 011 RC, 100 ECALL, 101 MRET; all other codes are NOP
- in_use_imm  in  1  source is zimm, not rs1
- in_src_zero  in  1  rs1 index (or zimm) is 0
- in_csr_addr  in  12  CSR address
- in_rs1_val  in  32  rs1 value
- in_zimm  in  5  immediate source
- in_rd  in  5  destination register
- in_pc  in  32  PC of the op
- csr_rd_addr  out  12  CSR file read address
- csr_wr_addr  out  12  CSR file write address
- csr_wren  out  1  CSR write strobe
- csr_wdata  out  32  CSR write data
- csr_ecallwr  out  1  trap write (mepc/mcause)
- csr_ecallrd  out  1  force mtvec read
- csr_mret  out  1  force mepc read
- csr_ecall_pkg  out  64  {mcause[63:32], mepc[31:0]}
- csr_rdata  in  32  CSR file read data (combinational)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_rd  out  5  destination
- out_rd_wen  out  1  GPR write enable
- out_rd_data  out  32  old CSR value
- out_redirect  out  1  PC redirect request
- out_redirect_pc  out  32  redirect target

Behaviour:
- Reset: state IDLE, in_ready=1, and every other output is 0, including all strobes, addresses, data, out_valid and out_redirect.
- FSM states: IDLE, EXEC, TRAP, RESP.
- IDLE:
  - in_valid && in_ready latches all in_* fields and moves to EXEC.
  - A NOP code still latches and completes with no side effects.
- EXEC (one cycle):
  - csr_rd_addr = latched addr for RW/RS/RC; 12'h000 for ECALL/MRET.
  - old = csr_rdata, sampled in this cycle. This is read-before-write: the write lands on the edge that ends EXEC.
  - src = in_use_imm ? {27'b0, zimm} : rs1_val.
  - New value: RW = src; RS = old | src; RC = old & ~src.
  - csr_wren=1, csr_wr_addr=addr, csr_wdata=new, except for RS/RC when in_src_zero=1, where csr_wren=0.
  - RW always writes, even when in_src_zero=1.
  - Result: out_rd_data=old, out_rd=rd, out_rd_wen=(rd!=0). Next state RESP.
  - ECALL: csr_ecallwr=1, csr_ecall_pkg={ECALL_CAUSE, pc}. Next state TRAP.
  - MRET: csr_mret=1, capture redirect_pc=csr_rdata (mepc), redirect=1, rd_wen=0. Next state RESP.
  - NOP: no strobes, rd_wen=0, redirect=0. Next state RESP.
- TRAP (ECALL only, one cycle):
  - csr_ecallrd=1, csr_rd_addr=0.
  - Capture redirect_pc=csr_rdata (mtvec), redirect=1, rd_wen=0. Next state RESP.
- RESP:
  - out_valid=1; result fields held stable until out_valid && out_ready.
  - On that handshake go to IDLE and clear out_valid and out_redirect.
  - Back-to-back ops: in_ready=1 only in IDLE, so there is no overlap.
- Strobes: all CSR-file strobes are single-cycle and are 0 outside EXEC/TRAP.
- Latency from the accept edge: CSR op / MRET / NOP out_valid 2 cycles later; ECALL 3 cycles later.
- Reset mid-op (any state): return to IDLE next edge, all strobes drop and the result is discarded. A CSR write is issued only if EXEC completed before reset.
- All arithmetic is 32-bit; zimm is zero-extended.

Test Plan:
- mtvec=0; CSRRW addr 305, rs1=0x80000100, rd=5 -> EXEC: csr_wren=1, wdata=0x80000100; RESP: rd_data=0, rd_wen=1; a following CSRRS x0 read of 305 returns 0x80000100.
- mstatus=0x1800; CSRRS 300 with zimm=0x8 -> wdata=0x1808, rd_data=0x1800. Then CSRRC 300 with in_src_zero=1 -> csr_wren=0, rd_data=0x1808.
- mtvec=0x80000100; ECALL at pc=0x80000040 -> EXEC: ecallwr=1, pkg=0x0000000B_80000040; TRAP: ecallrd=1; RESP: redirect=1, redirect_pc=0x80000100, rd_wen=0, 3-cycle latency.
- mepc=0x80000044; MRET -> csr_mret=1 for one cycle; redirect_pc=0x80000044 after 2 cycles.
- out_ready held 0 for 4 cycles in RESP -> outputs stable, in_ready=0, new in_valid ignored; release -> IDLE next cycle.
- rst asserted during TRAP -> next cycle all outputs 0, in_ready=1, no redirect emitted; mepc/mcause already written (11, pc) remain.
